// File: rtl/genius_pkg.sv
// Shared Genius definitions: colour and player-state encodings, LFSR seed/taps
// and the LFSR step function used by both the sequence player and the input checker.
package genius_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    RED    = 2'd1,
    YELLOW = 2'd2,
    BLUE   = 2'd3
  } color_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  localparam int LFSR_TAP_A = 15;
  localparam int LFSR_TAP_B = 13;
  localparam int LFSR_TAP_C = 12;
  localparam int LFSR_TAP_D = 10;

  // Fibonacci step: shift left, XOR of the taps enters at bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B] ^ cur[LFSR_TAP_C] ^ cur[LFSR_TAP_D]};
  endfunction

  function automatic logic [3:0] color_onehot(input color_t c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load; load takes priority over advance.
module lfsr16
  import genius_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        advance,
  output logic [15:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= LFSR_DEFAULT_SEED;
    end else if (load) begin
      value <= load_val;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/sequence_player.sv
// Plays the Genius colour sequence for the current round: each step lights one LED
// for ON_CYCLES, then stays dark for OFF_CYCLES; pulses done when the round is shown.
module sequence_player
  import genius_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] level,
  input  logic [15:0]           seed,
  input  logic                  seed_load,
  output logic                  busy,
  output logic [3:0]            led,
  output logic [1:0]            color,
  output logic                  color_valid,
  output logic                  done
);

  localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] ON_RELOAD  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_RELOAD = TIMER_W'(OFF_CYCLES - 1);

  state_t                  state;
  logic [15:0]             seed_reg;
  logic [DATA_WIDTH-1:0]   level_q;
  logic [DATA_WIDTH-1:0]   step;
  logic [DATA_WIDTH-1:0]   step_next;
  logic [TIMER_W-1:0]      timer;
  logic [15:0]             lfsr_value;
  logic                    lfsr_load;
  logic                    lfsr_advance;
  color_t                  seed_color;
  color_t                  next_color;

  // Zero is a lock-up state for the LFSR, so it is replaced by the default seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_reg <= LFSR_DEFAULT_SEED;
    end else if (seed_load) begin
      seed_reg <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    end
  end

  lfsr16 u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (seed_reg),
    .advance  (lfsr_advance),
    .value    (lfsr_value)
  );

  // Outputs are registered, so the colour entering ON is looked up one step ahead.
  always_comb begin
    step_next    = step + DATA_WIDTH'(1);
    seed_color   = color_t'(2'(seed_reg));
    next_color   = color_t'(2'(lfsr_next(lfsr_value)));
    lfsr_load    = (state == ST_IDLE) && start && (level != '0);
    lfsr_advance = (state == ST_OFF) && (timer == '0) && (step_next != level_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      level_q     <= '0;
      step        <= '0;
      timer       <= '0;
      busy        <= 1'b0;
      led         <= 4'b0000;
      color       <= 2'b00;
      color_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      color_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (level != '0) begin
              state       <= ST_ON;
              level_q     <= level;
              step        <= '0;
              timer       <= ON_RELOAD;
              busy        <= 1'b1;
              color       <= seed_color;
              led         <= color_onehot(seed_color);
              color_valid <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_ON: begin
          if (timer == '0) begin
            state <= ST_OFF;
            timer <= OFF_RELOAD;
            led   <= 4'b0000;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end
        ST_OFF: begin
          if (timer == '0) begin
            step <= step_next;
            if (step_next == level_q) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state       <= ST_ON;
              timer       <= ON_RELOAD;
              color       <= next_color;
              led         <= color_onehot(next_color);
              color_valid <= 1'b1;
            end
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_player.sv
// Randomised self-checking bench for sequence_player with ON_CYCLES=3, OFF_CYCLES=2.
module tb_sequence_player;

  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int P   = ON + OFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        seed_load = 1'b0;
  logic [7:0]  level = 8'd0;
  logic [15:0] seed = 16'h0000;
  logic        busy;
  logic [3:0]  led;
  logic [1:0]  color;
  logic        color_valid;
  logic        done;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] seed_model = 16'hACE1;
  logic [1:0]  first_col = 2'b00;

  always #5 clk = ~clk;

  sequence_player #(
    .DATA_WIDTH (8),
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .level       (level),
    .seed        (seed),
    .seed_load   (seed_load),
    .busy        (busy),
    .led         (led),
    .color       (color),
    .color_valid (color_valid),
    .done        (done)
  );

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      n_cmp++;
      if ({busy, led, color_valid, done} !== 7'b0) begin
        n_bad++;
        $display("FAIL %s idle cycle %0d: busy,led,cv,done=%b required 0000000", name, i,
                 {busy, led, color_valid, done});
      end
    end
  endtask

  // Pulses start with lvl, then checks every cycle up to and including the done cycle.
  task automatic play(input string name, input int lvl, input bit disturb,
                      input bit inject_seed, input logic [15:0] inj_val);
    logic [1:0]  cols[$];
    logic [15:0] v;
    int          total, s, ph;
    logic        e_busy, e_cv, e_done, col_care;
    logic [3:0]  e_led;
    logic [1:0]  e_col;
    v = seed_model;
    cols = {};
    for (int i = 0; i < lvl; i++) begin
      cols.push_back(v[1:0]);
      v = ref_step(v);
    end
    total = lvl * P + 1;
    start = 1'b1;
    level = 8'(lvl);
    for (int t = 1; t <= total; t++) begin
      tick();
      start = 1'b0;
      seed_load = 1'b0;
      if (t == 1) first_col = color;
      if (t <= lvl * P) begin
        s = (t - 1) / P;
        ph = (t - 1) % P;
        e_busy = 1'b1;
        e_cv = (ph == 0);
        e_led = (ph < ON) ? (4'b0001 << cols[s]) : 4'b0000;
        e_done = 1'b0;
        e_col = cols[s];
        col_care = 1'b1;
      end else begin
        e_busy = 1'b0;
        e_cv = 1'b0;
        e_led = 4'b0000;
        e_done = 1'b1;
        col_care = (lvl > 0);
        e_col = (lvl > 0) ? cols[lvl-1] : 2'b00;
      end
      n_cmp++;
      if ({busy, led, color_valid, done} !== {e_busy, e_led, e_cv, e_done}) begin
        n_bad++;
        $display("FAIL %s t=%0d busy,led,cv,done: got %b required %b", name, t,
                 {busy, led, color_valid, done}, {e_busy, e_led, e_cv, e_done});
      end
      if (col_care) begin
        n_cmp++;
        if (color !== e_col) begin
          n_bad++;
          $display("FAIL %s t=%0d color: got %0d required %0d", name, t, color, e_col);
        end
      end
      if (disturb && t < total && (t == 2 || t == P + 1 || t == total - 1)) begin
        start = 1'b1;
        level = 8'($urandom);
      end
      if (inject_seed && t == 2) begin
        seed_load = 1'b1;
        seed = inj_val;
        seed_model = (inj_val == 16'h0000) ? 16'hACE1 : inj_val;
      end
    end
  endtask

  task automatic load_seed(input logic [15:0] val);
    seed = val;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    seed_model = (val == 16'h0000) ? 16'hACE1 : val;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_cmp++;
    if ({busy, led, color, color_valid, done} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_state: got %b required 000000000", {busy, led, color, color_valid, done});
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    load_seed(16'h1234);
    start = 1'b1;
    level = 8'd2;
    tick();
    start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, led, color, color_valid, done} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_mid_on: got %b required 000000000", {busy, led, color, color_valid, done});
    end
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;
    seed_model = 16'hACE1;
    tick();
    play("reset_replay", 1, 1'b0, 1'b0, 16'h0000);
    n_cmp++;
    if (first_col !== 2'd1) begin
      n_bad++;
      $display("FAIL reset_first_color: got %0d required 1", first_col);
    end
    check_idle("reset_after", 2);
  endtask

  task automatic test_default_seed();
    play("default_seed", 3, 1'b0, 1'b0, 16'h0000);
    check_idle("default_after", 2);
  endtask

  task automatic test_zero_level();
    play("zero_level", 0, 1'b0, 1'b0, 16'h0000);
    check_idle("zero_after", 3);
  endtask

  task automatic test_start_while_busy();
    play("start_busy", 4, 1'b1, 1'b0, 16'h0000);
    check_idle("start_busy_after", 1);
  endtask

  task automatic test_seed_load();
    load_seed(16'h0000);
    play("seed_zero", 3, 1'b0, 1'b0, 16'h0000);
    tick();
    play("seed_mid_play", 3, 1'b0, 1'b1, 16'h0003);
    tick();
    play("seed_next", 2, 1'b0, 1'b0, 16'h0000);
    n_cmp++;
    if (first_col !== 2'd3) begin
      n_bad++;
      $display("FAIL seed_next_first_color: got %0d required 3", first_col);
    end
    check_idle("seed_after", 1);
  endtask

  task automatic test_back_to_back();
    load_seed(16'hACE1);
    play("b2b_first", 3, 1'b0, 1'b0, 16'h0000);
    tick();
    play("b2b_second", 3, 1'b0, 1'b0, 16'h0000);
    check_idle("b2b_after", 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      load_seed((i == 3) ? 16'h0000 : 16'($urandom));
      play("random", $urandom_range(1, 8), 1'($urandom), 1'($urandom), 16'($urandom));
      check_idle("random_after", 1);
    end
  endtask

  task automatic test_max_level();
    load_seed(16'($urandom));
    play("max_level", 255, 1'b1, 1'b0, 16'h0000);
    check_idle("max_after", 2);
  endtask

  initial begin
    test_reset();
    test_default_seed();
    test_zero_level();
    test_start_while_busy();
    test_seed_load();
    test_back_to_back();
    test_random();
    test_max_level();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
